matrix_buffer: RTL and testbench
================================

MATRIX_BUFFER -- requirements
Module: matrix_buffer

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension (NxN), legal 2..8.
REQ-002 SHALL have parameter DATA_W, default 32, meaning element width in bits, legal 8..32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_row  input  N*DATA_W  one matrix row; column c at bits [c*DATA_W +: DATA_W].
REQ-006 SHALL have port in_valid  input  1  in_row holds valid data.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a row this cycle.
REQ-008 SHALL have port start  input  1  single-cycle request to begin serial shift-out.
REQ-009 SHALL have port flush  input  1  abort; discard contents and return to LOAD.
REQ-010 SHALL have port full  output  1  all N rows loaded, awaiting start.
REQ-011 SHALL have port out_bits  output  N*N  one bit per element; element (r,c) at bit r*N+c.
REQ-012 SHALL have port out_valid  output  1  out_bits valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out_bits this cycle.
REQ-014 SHALL have port out_last  output  1  current out_bits is the LSB (final bit) of every element.

Function
REQ-015 SHALL implement FSM states LOAD, FULL, SHIFT.
REQ-016 In LOAD, in_ready SHALL be 1; row accepted when in_valid&&in_ready, written to row index row_cnt, row_cnt incremented.
REQ-017 Accepting row N-1 SHALL move to FULL the next cycle with row_cnt wrapped to 0; in_ready SHALL be 0 outside LOAD.
REQ-018 In FULL, full SHALL be 1; start SHALL move to SHIFT with bit_cnt=DATA_W-1; start in LOAD or SHIFT SHALL be ignored.
REQ-019 In SHIFT, out_valid SHALL be 1 and out_bits[r*N+c] SHALL equal bit bit_cnt of element (r,c), i.e. MSB first.
REQ-020 bit_cnt SHALL decrement only on out_valid&&out_ready; out_bits SHALL hold stable while out_ready=0.
REQ-021 out_last SHALL be 1 exactly when in SHIFT with bit_cnt=0; handshake on that beat SHALL return to LOAD.
REQ-022 Latency: first out_valid SHALL occur the cycle after start is sampled in FULL; a full drain with out_ready=1 SHALL take exactly DATA_W cycles.
REQ-023 flush SHALL, in any state, return to LOAD next cycle, zero row_cnt and bit_cnt, deassert out_valid/full; stored data SHALL be zeroed.
REQ-024 flush and start in the same cycle: flush SHALL win; flush with in_valid in LOAD: row SHALL NOT be written.
REQ-025 Stored matrix SHALL be unchanged throughout FULL and SHIFT (no writes outside LOAD).

Reset
REQ-026 While rst_n=0, state SHALL be LOAD, row_cnt=0, bit_cnt=0, all stored elements 0.
REQ-027 Reset outputs: in_ready=1, full=0, out_valid=0, out_last=0, out_bits=0.
REQ-028 Reset asserted mid-SHIFT or mid-LOAD SHALL take effect immediately (asynchronously) and discard partial data.

Configuration
REQ-029 Macro MATRIX_BUFFER_TRANSPOSE_EN SHALL, when defined, add input port transpose (1 bit), sampled with the first accepted row (row_cnt=0) and held until return to LOAD.
REQ-030 With the macro defined and transpose=1, row k SHALL be stored as column k, so out_bits[r*N+c] carries element (c,r) of the input; transpose=0 SHALL behave identically to the macro-undefined build.
REQ-031 Without the macro, no transpose port SHALL exist and storage SHALL be row-major only.

Verification
REQ-032 Reset release, N=4, DATA_W=32 -> in_ready=1, full=0, out_valid=0, out_bits=0.
REQ-033 Load 4 rows with element (r,c)=32'h80000000 only at (1,2), others 0, then start -> first beat out_bits=16'h0040, next 31 beats 0, out_last on beat 32, then in_ready=1.
REQ-034 All elements 32'h00000001, out_ready toggling 1/0 -> exactly 32 accepted beats, out_bits=16'h0000 for beats 1-31 and 16'hFFFF on beat 32, values held on stalled cycles.
REQ-035 flush asserted with start in FULL, and separately at bit_cnt=17 in SHIFT -> LOAD next cycle, out_valid=0, subsequent drain of freshly loaded zero matrix yields out_bits=0.
REQ-036 rst_n pulsed low after 2 rows loaded -> full=0 immediately; 4 new rows then needed before full=1.
REQ-037 MATRIX_BUFFER_TRANSPOSE_EN defined, transpose=1, element (0,3)=32'hFFFFFFFF only -> every beat out_bits=16'h1000 (bit 3*4+0).

Source files
------------

// File: rtl/matrix_buffer_if.sv
// Row-load / bit-serial-drain bus of matrix_buffer.
// The master drives rows and pulls bit-planes; the slave is the buffer.
interface matrix_buffer_if #(
  parameter int N      = 4,
  parameter int DATA_W = 32
);
  logic [N*DATA_W-1:0] in_row;
  logic                in_valid;
  logic                in_ready;
  logic                start;
  logic                flush;
  logic                full;
  logic [N*N-1:0]      out_bits;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output in_row, in_valid, start, flush, out_ready,
    input  in_ready, full, out_bits, out_valid, out_last
  );

  modport slave (
    input  in_row, in_valid, start, flush, out_ready,
    output in_ready, full, out_bits, out_valid, out_last
  );
endinterface

// File: rtl/matrix_buffer.sv
// NxN matrix buffer: loads N rows, then shifts all elements out MSB-first as N*N-bit planes.
// Optional macro MATRIX_BUFFER_TRANSPOSE_EN adds a transpose input that stores rows as columns.
module matrix_buffer #(
  parameter int N      = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
  input  logic                transpose,
`endif
  matrix_buffer_if.slave      bus,
  output logic [1:0]          dbg_state_o
);

  localparam int RW = $clog2(N);
  localparam int BW = $clog2(DATA_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FULL  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] mem_q [N][N];
  logic              row_we;
  logic              tp_eff;
  logic [N*N-1:0]    out_bits_w;

  // Handshakes: a row transfers on a rising edge where in_valid && in_ready;
  // a bit-plane transfers where out_valid && out_ready. A valid side holds its
  // data stable until the transfer; ready may change freely.
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.full      = (state_q == ST_FULL);
  assign bus.out_valid = (state_q == ST_SHIFT);
  assign bus.out_last  = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
  assign bus.out_bits  = out_bits_w;
  assign dbg_state_o   = state_q;

  assign row_we = (state_q == ST_LOAD) && bus.in_valid && !bus.flush;

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
  logic tp_q, tp_d;

  // Row 0 carries its own transpose sample; later rows use the held value.
  assign tp_eff = (row_cnt_q == '0) ? transpose : tp_q;

  always_comb begin
    tp_d = tp_q;
    if (bus.flush)                     tp_d = 1'b0;
    else if (row_we && row_cnt_q == '0) tp_d = transpose;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tp_q <= 1'b0;
    else        tp_q <= tp_d;
  end
`else
  assign tp_eff = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          if (row_cnt_q == ROW_LAST) begin
            state_d   = ST_FULL;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (bus.start) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = BIT_TOP;
        end
      end
      ST_SHIFT: begin
        if (bus.out_ready) begin
          if (bit_cnt_q == '0) state_d = ST_LOAD;
          else                 bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    if (bus.flush) begin
      state_d   = ST_LOAD;
      row_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      row_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Transposed write: incoming row k lands in column k, so mem[r][k] = in_row[col r].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem_q[r][c] <= '0;
    end else if (bus.flush) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem_q[r][c] <= '0;
    end else if (row_we) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (tp_eff ? (RW'(c) == row_cnt_q) : (RW'(r) == row_cnt_q))
            mem_q[r][c] <= bus.in_row[(tp_eff ? r : c)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    out_bits_w = '0;
    if (state_q == ST_SHIFT)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          out_bits_w[r*N+c] = mem_q[r][c][bit_cnt_q];
  end

endmodule

// File: tb/tb_matrix_buffer.sv
// Self-checking bench for matrix_buffer (N=4, DATA_W=32): a matrix-level model
// predicts every bit-plane; directed cases pin literal values.
module tb_matrix_buffer;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NN = N*N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
  logic       transpose;
`endif

  always #5 clk = ~clk;

  matrix_buffer_if #(.N(N), .DATA_W(W)) bus ();

  matrix_buffer #(.N(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    .transpose  (transpose),
`endif
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]  m_in [N][N];
  int            m_cnt;
  bit            m_full;
  bit            m_tp;
  logic [NN-1:0] exp_q[$];

  function automatic logic cur_tp();
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    return transpose;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m_in[r][c] = '0;
    m_cnt  = 0;
    m_full = 0;
    m_tp   = 0;
    exp_q.delete();
  endtask

  task automatic build_beats();
    logic [NN-1:0] beat;
    logic [W-1:0]  e;
    for (int b = W-1; b >= 0; b--) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          e = m_tp ? m_in[c][r] : m_in[r][c];
          beat[r*N+c] = (e >> b) & 1;
        end
      exp_q.push_back(beat);
    end
  endtask

  initial model_clear();

  always @(negedge clk) begin
    if (!rst_n) model_clear();
    chk("in_ready",  bus.in_ready,  (!m_full && exp_q.size() == 0));
    chk("full",      bus.full,      m_full);
    chk("out_valid", bus.out_valid, (exp_q.size() != 0));
    chk("out_last",  bus.out_last,  (exp_q.size() == 1));
    if (exp_q.size() != 0) chk("out_bits", bus.out_bits, exp_q[0]);
    if (rst_n) begin
      if (bus.flush) begin
        model_clear();
      end else if (!m_full && exp_q.size() == 0) begin
        if (bus.in_valid) begin
          if (m_cnt == 0) m_tp = cur_tp();
          for (int c = 0; c < N; c++) m_in[m_cnt][c] = bus.in_row[c*W +: W];
          m_cnt++;
          if (m_cnt == N) begin
            m_full = 1;
            m_cnt  = 0;
          end
        end
      end else if (m_full) begin
        if (bus.start) begin
          build_beats();
          m_full = 0;
        end
      end else if (bus.out_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] stim [N][N];

  function automatic logic [N*W-1:0] pack_row(input int k);
    logic [N*W-1:0] row;
    for (int c = 0; c < N; c++) row[c*W +: W] = stim[k][c];
    return row;
  endfunction

  task automatic fill_stim(input int mode, input logic [W-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        stim[r][c] = (mode == 0) ? v : $urandom;
  endtask

  task automatic load_rows(input int first, input int count, input bit gaps);
    int k   = 0;
    int cyc = 0;
    while (k < count && cyc < 200) begin
      @(posedge clk); #1;
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_row   = pack_row(first + k);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) k++;
      cyc++;
    end
    chk("load_rows_done", k, count);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input int mode, input int max_beats, output int beats, output int vcyc,
                       output logic v0, output logic [NN-1:0] first, output logic [NN-1:0] last);
    bit done = 0;
    int cyc  = 0;
    beats = 0; vcyc = 0; v0 = 0; first = '0; last = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) v0 = bus.out_valid;
      if (bus.out_valid) vcyc++;
      if (bus.out_valid && bus.out_ready) begin
        if (beats == 0) first = bus.out_bits;
        beats++;
        if (bus.out_last) begin
          last = bus.out_bits;
          done = 1;
        end else if (max_beats != 0 && beats == max_beats) begin
          done = 1;
        end
      end
      @(posedge clk); #1;
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
    chk("drain_done", done, 1);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int            beats, vcyc;
  logic          v0;
  logic [NN-1:0] first, last;

  initial begin
    rst_n        = 1'b0;
    bus.in_row   = '0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    transpose    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_full",      bus.full,      0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last",  bus.out_last,  0);
    chk("rst_out_bits",  bus.out_bits,  16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single set MSB at (1,2), full-rate drain.
    fill_stim(0, '0);
    stim[1][2] = 32'h8000_0000;
    load_rows(0, N, 0);
    bus.out_ready = 1'b1;
    do_start();
    drain(0, 0, beats, vcyc, v0, first, last);
    chk("msb_first_latency", v0, 1);
    chk("msb_first_beat",    first, 16'h0040);
    chk("msb_beats",         beats, 32);
    chk("msb_valid_cycles",  vcyc, 32);
    chk("msb_last_beat",     last, 16'h0000);
    @(negedge clk);
    chk("msb_back_to_load",  bus.in_ready, 1);

    // All ones with stalls every other cycle.
    fill_stim(0, 32'h0000_0001);
    load_rows(0, N, 1);
    bus.out_ready = 1'b1;
    do_start();
    drain(1, 0, beats, vcyc, v0, first, last);
    chk("ones_beats",      beats, 32);
    chk("ones_first_beat", first, 16'h0000);
    chk("ones_last_beat",  last,  16'hFFFF);

    // flush together with start in FULL.
    fill_stim(1, '0);
    load_rows(0, N, 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_start_out_valid", bus.out_valid, 0);
    chk("flush_start_full",      bus.full, 0);
    chk("flush_start_in_ready",  bus.in_ready, 1);

    // flush in SHIFT with bit_cnt at 17.
    fill_stim(1, '0);
    load_rows(0, N, 0);
    bus.out_ready = 1'b1;
    do_start();
    drain(0, 14, beats, vcyc, v0, first, last);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_shift_out_valid", bus.out_valid, 0);
    chk("flush_shift_in_ready",  bus.in_ready, 1);
    fill_stim(0, '0);
    load_rows(0, N, 0);
    bus.out_ready = 1'b1;
    do_start();
    drain(0, 0, beats, vcyc, v0, first, last);
    chk("zero_first_beat", first, 16'h0000);
    chk("zero_last_beat",  last,  16'h0000);
    chk("zero_beats",      beats, 32);

    // Async reset mid-LOAD, then a full reload.
    fill_stim(1, '0);
    load_rows(0, 2, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_load_full",     bus.full, 0);
    chk("rst_mid_load_in_ready", bus.in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_rows(0, 3, 0);
    @(negedge clk);
    chk("reload_3_rows_full", bus.full, 0);
    load_rows(3, 1, 0);
    @(negedge clk);
    chk("reload_4_rows_full", bus.full, 1);

    // Async reset mid-SHIFT.
    bus.out_ready = 1'b1;
    do_start();
    drain(0, 5, beats, vcyc, v0, first, last);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_shift_out_valid", bus.out_valid, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    fill_stim(0, '0);
    stim[0][3] = 32'hFFFF_FFFF;
    transpose  = 1'b1;
    load_rows(0, N, 0);
    transpose  = 1'b0;
    bus.out_ready = 1'b1;
    do_start();
    drain(0, 0, beats, vcyc, v0, first, last);
    chk("tp_first_beat", first, 16'h1000);
    chk("tp_last_beat",  last,  16'h1000);
`endif

    // Randomized rounds: gapped loads, ignored start/in_valid, random back-pressure.
    for (int it = 0; it < 8; it++) begin
      fill_stim(1, '0);
      if ($urandom_range(0, 1) == 1) do_start();
      load_rows(0, N, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_row   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      do_start();
      drain(2, 0, beats, vcyc, v0, first, last);
      chk("rand_beats", beats, 32);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
